pc: RTL



---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_if.sv | 22 ++
 rtl/hack_defs.sv | 8 +
 rtl/word_reg.sv | 23 ++
 rtl/pc.sv | 47 ++++
 5 files changed

// File: rtl/pc_pkg.sv
// Program counter package: width/reset constants and next-value selection.
`include "hack_defs.sv"

package pc_pkg;

    localparam int unsigned PC_WIDTH = `HACK_WORD_W;
    localparam logic [15:0] PC_RESET_VALUE = `HACK_PC_RESET;

    // Source of the next counter value.
    typedef enum logic [1:0] {
        SelHold  = 2'd0,
        SelInc   = 2'd1,
        SelLoad  = 2'd2,
        SelClear = 2'd3
    } pc_sel_e;

    // Synchronous clear beats load, load beats increment, otherwise hold.
    function automatic pc_sel_e pc_select(input logic reset, input logic load,
                                          input logic inc);
        if (reset) begin
            return SelClear;
        end else if (load) begin
            return SelLoad;
        end else if (inc) begin
            return SelInc;
        end
        return SelHold;
    endfunction

endpackage

// File: rtl/pc_if.sv
// Control/data bundle between the CPU control path and the program counter.
interface pc_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             reset;
    logic [WIDTH-1:0] out;

    // Control path side: drives jump target and controls, observes the address.
    modport master (
        output in, load, inc, reset,
        input  out
    );

    // Program counter side.
    modport slave (
        input  in, load, inc, reset,
        output out
    );
endinterface

// File: rtl/hack_defs.sv
// Shared Hack-platform constants: word width and the program counter reset value.
`ifndef HACK_DEFS_SV
`define HACK_DEFS_SV

`define HACK_WORD_W   16
`define HACK_PC_RESET 16'h0000

`endif // HACK_DEFS_SV

// File: rtl/word_reg.sv
// Word-wide register with load enable and asynchronous active-low reset.
// Also usable for the A and D registers.
module word_reg #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on the rising edge when load is set; async reset to RESET_VALUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc.sv
// Hack CPU program counter: registered address with clear/load/increment/hold.
module pc
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
    input  logic clk,
    input  logic rst_n,
    pc_if.slave  bus
);

    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] next_val;
    pc_sel_e          sel;

    // Modulo 2^WIDTH incrementer; carry out is dropped on purpose.
    assign inc_val = cur_val + WIDTH'(1);

    // Next-value mux; hold is handled here so the register can load every cycle.
    always_comb begin
        next_val = cur_val;
        sel      = pc_select(bus.reset, bus.load, bus.inc);
        unique case (sel)
            SelClear: next_val = RESET_VALUE;
            SelLoad:  next_val = bus.in;
            SelInc:   next_val = inc_val;
            SelHold:  next_val = cur_val;
            default:  next_val = cur_val;
        endcase
    end

    word_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (1'b1),
        .d     (next_val),
        .q     (cur_val)
    );

    assign bus.out = cur_val;

endmodule
